regfile_wb: RTL

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/regfile_wb.sv | 82 ++++++++
 1 files changed

// File: rtl/regfile_wb.sv
// Register file with a write-back pipeline register and EX/MEM/WB read bypassing.
// Register 0 is hard-wired to zero, and reset clears all state asynchronously.
module regfile_wb #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        re1_i,
  input  logic [4:0]  raddr1_i,
  output logic [31:0] rdata1_o,
  input  logic        re2_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata2_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o
);

  logic [31:0] regs [NREG];
  logic        wb_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
    end else if (flush_i) begin
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
    end else if (!stall_i) begin
      wb_wd_o    <= mem_wd_i;
      wb_wreg_o  <= mem_wreg_i;
      wb_wdata_o <= mem_wdata_i;
    end
  end

  // A stalled entry is rewritten every cycle; the repeated write is harmless.
  assign wb_write = wb_wreg_o && (wb_wd_o != 5'd0) && (int'(wb_wd_o) < NREG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_write) begin
      regs[wb_wd_o] <= wb_wdata_o;
    end
  end

  // Youngest producer wins: EX, then MEM, then WB, then the array.
  function automatic logic [31:0] read_port(input logic re, input logic [4:0] addr);
    logic [31:0] data;
    data = '0;
    if (!rst || !re || addr == 5'd0) begin
      data = '0;
    end else if (ex_wreg_i && ex_wd_i == addr) begin
      data = ex_wdata_i;
    end else if (mem_wreg_i && mem_wd_i == addr) begin
      data = mem_wdata_i;
    end else if (wb_wreg_o && wb_wd_o == addr) begin
      data = wb_wdata_o;
    end else if (int'(addr) < NREG) begin
      data = regs[addr];
    end
    return data;
  endfunction

  always_comb begin
    rdata1_o = read_port(re1_i, raddr1_i);
    rdata2_o = read_port(re2_i, raddr2_i);
  end

endmodule
